ctrl_mem: RTL and testbench
===========================

CTRL_MEM -- requirements
Module: ctrl_mem

Interface
REQ-001 Parameter LAT, default 2, memTrans access length in CLK cycles; legal range 1..15.
REQ-002 CLK  input  1  single clock; all state changes on its rising edge.
REQ-003 iCLR  input  1  reset, asynchronous, active-low.
REQ-004 req0  input  1  requester 0 access request.
REQ-005 le0  input  1  requester 0 operation: 1 write, 0 read.
REQ-006 dir0  input  `Ndir+1  requester 0 address.
REQ-007 dato0  input  32  requester 0 write data.
REQ-008 req1, le1, dir1, dato1  inputs  1/1/`Ndir+1/32  requester 1, same meaning as requester 0.
REQ-009 gnt0, gnt1  output  1 each  requester owns memTrans.
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-011 rdato  output  32  read result, valid in the cycle ack0 or ack1 is high.
REQ-012 mem_dir  output  `Ndir+1  address to memTrans dir.
REQ-013 mem_LE  output  1  write enable to memTrans LE.
REQ-014 mem_dato_w  output  32  write data to memTrans.
REQ-015 mem_dato_r  input  32  read data from memTrans.
REQ-016 ocupado  output  1  high whenever state is not REPOSO.

Function
REQ-017 FSM states: REPOSO, ACCESO, FIN.
REQ-018 REPOSO: no request -> stay; any request -> ACCESO next cycle, winner's gnt set, winner's dir/le/dato registered onto mem_dir/mem_LE latch/mem_dato_w.
REQ-019 ACCESO lasts exactly LAT cycles, timed by a 4-bit counter loaded with LAT-1 on entry and decremented to 0.
REQ-020 mem_LE high only during ACCESO cycles and only for a write; low in every other state.
REQ-021 Last ACCESO cycle: for a read, mem_dato_r captured into rdato; for a write, rdato holds its previous value.
REQ-022 FIN: one cycle, ack of the granted requester = 1, gnt still held; next state REPOSO with gnt cleared.
REQ-023 Latency: req high in REPOSO at cycle n -> gnt at n+1, ack at n+LAT+1, REPOSO at n+LAT+2; minimum one REPOSO cycle between accesses.
REQ-024 Inputs of the granted requester are ignored after the REPOSO sampling cycle; dropping req mid-access does not abort, ack still issued.
REQ-025 A request arriving while not in REPOSO waits; no request is lost while req is held.
REQ-026 gnt0 and gnt1 never high simultaneously; ack0 and ack1 never high simultaneously.
REQ-027 mem_dir and mem_dato_w hold the last registered value outside ACCESO.

Reset
REQ-028 iCLR low forces immediately, without CLK: state REPOSO, counter 0, gnt0/gnt1/ack0/ack1/mem_LE/ocupado 0, mem_dir 0, mem_dato_w 0, rdato 0, priority pointer "last served = 1".
REQ-029 Reset during ACCESO or FIN aborts the access with no ack; first request after iCLR rises is handled from REPOSO.

Configuration
REQ-030 Macro CTRL_MEM_RR_EN defined: round-robin; both requesting in REPOSO -> grant the requester not last served; pointer updated on every grant.
REQ-031 CTRL_MEM_RR_EN undefined: fixed priority, requester 0 always wins a tie; pointer logic absent.

Verification
REQ-032 LAT=2, req0=1, le0=1, dir0=3, dato0=32'hCAFE0001 at cycle 0 -> gnt0 cycles 1-3, mem_LE=1 cycles 1-2, mem_dir=3, ack0 at cycle 3.
REQ-033 Read back: req0=1, le0=0, dir0=3, memory model returns 32'hCAFE0001 -> ack0 pulse with rdato=32'hCAFE0001, mem_LE stays 0.
REQ-034 req0 and req1 held high 6 accesses, CTRL_MEM_RR_EN defined -> grants ordered 0,1,0,1,0,1; undefined -> all six to requester 0.
REQ-035 req1 rises during requester-0 ACCESO -> gnt1 rises one cycle after requester-0 FIN/REPOSO, never overlaps gnt0.
REQ-036 iCLR pulsed low mid-ACCESO (asynchronous, between edges) -> all outputs 0 immediately, no ack; next request completes normally.
REQ-037 LAT=1 and LAT=15 sweeps -> ack exactly LAT+1 cycles after the sampling cycle, ocupado high LAT+1 cycles.

Source files
------------

// File: rtl/ctrl_mem.sv
// ctrl_mem: arbitrates two requesters onto memTrans with a fixed LAT-cycle access window.
// Define CTRL_MEM_RR_EN for round-robin arbitration; otherwise requester 0 wins every tie.
`ifndef Ndir
`define Ndir 7
`endif
module ctrl_mem #(
  parameter int unsigned LAT = 2
) (
  input  logic            CLK,
  input  logic            iCLR,
  input  logic            req0,
  input  logic            le0,
  input  logic [`Ndir:0]  dir0,
  input  logic [31:0]     dato0,
  input  logic            req1,
  input  logic            le1,
  input  logic [`Ndir:0]  dir1,
  input  logic [31:0]     dato1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            ack0,
  output logic            ack1,
  output logic [31:0]     rdato,
  output logic [`Ndir:0]  mem_dir,
  output logic            mem_LE,
  output logic [31:0]     mem_dato_w,
  input  logic [31:0]     mem_dato_r,
  output logic            ocupado
);
  typedef enum logic [1:0] {REPOSO, ACCESO, FIN} state_t;
  state_t     state;
  logic [3:0] cnt;
  logic       pick1;
`ifdef CTRL_MEM_RR_EN
  logic       last;
  assign pick1 = req1 & (~req0 | ~last);
`else
  assign pick1 = req1 & ~req0;
`endif
  // mem_LE doubles as the latched operation: low during ACCESO means a read
  always_ff @(posedge CLK or negedge iCLR)
    if (!iCLR) begin
      state      <= REPOSO;
      cnt        <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      mem_LE     <= 1'b0;
      ocupado    <= 1'b0;
      mem_dir    <= '0;
      mem_dato_w <= '0;
      rdato      <= '0;
`ifdef CTRL_MEM_RR_EN
      last       <= 1'b1;
`endif
    end else
      case (state)
        REPOSO:
          if (req0 | req1) begin
            state      <= ACCESO;
            cnt        <= 4'(LAT - 1);
            gnt0       <= ~pick1;
            gnt1       <= pick1;
            mem_dir    <= pick1 ? dir1 : dir0;
            mem_LE     <= pick1 ? le1 : le0;
            mem_dato_w <= pick1 ? dato1 : dato0;
            ocupado    <= 1'b1;
`ifdef CTRL_MEM_RR_EN
            last       <= pick1;
`endif
          end
        ACCESO:
          if (cnt == 4'd0) begin
            state  <= FIN;
            mem_LE <= 1'b0;
            ack0   <= gnt0;
            ack1   <= gnt1;
            if (!mem_LE) rdato <= mem_dato_r;
          end else
            cnt <= cnt - 4'd1;
        FIN: begin
          state   <= REPOSO;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          ocupado <= 1'b0;
        end
        default: state <= REPOSO;
      endcase
endmodule

// File: tb/tb_ctrl_mem.sv
// tb_ctrl_mem: randomized directed bench for ctrl_mem checked against a transaction-level model.
`ifndef Ndir
`define Ndir 7
`endif
module tb_ctrl_mem;
  localparam int AW  = `Ndir + 1;
  localparam int LAT = 2;
`ifdef CTRL_MEM_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic          CLK = 1'b0;
  logic          iCLR;
  logic          req0, le0, req1, le1;
  logic [AW-1:0] dir0, dir1, mem_dir;
  logic [31:0]   dato0, dato1, rdato, mem_dato_w, mem_dato_r;
  logic          gnt0, gnt1, ack0, ack1, mem_LE, ocupado;
  logic [31:0]   mem     [2**AW] = '{default: 32'h0};
  logic [31:0]   ref_mem [2**AW] = '{default: 32'h0};
  logic          last_ref;
  logic [31:0]   exp_rd;
  int            checks = 0;
  int            errors = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) if (mem_LE) mem[mem_dir] <= mem_dato_w;
  assign mem_dato_r = mem[mem_dir];

  ctrl_mem #(.LAT(LAT)) dut (
    .CLK(CLK), .iCLR(iCLR),
    .req0(req0), .le0(le0), .dir0(dir0), .dato0(dato0),
    .req1(req1), .le1(le1), .dir1(dir1), .dato1(dato1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .rdato(rdato),
    .mem_dir(mem_dir), .mem_LE(mem_LE), .mem_dato_w(mem_dato_w),
    .mem_dato_r(mem_dato_r), .ocupado(ocupado)
  );

  // latency-extreme instances sharing the same request inputs
  for (genvar g = 0; g < 2; g++) begin : sw
    logic          g0, g1, k0, k1, we, oc;
    logic [AW-1:0] md;
    logic [31:0]   rd, wd;
    ctrl_mem #(.LAT(g ? 15 : 1)) u (
      .CLK(CLK), .iCLR(iCLR),
      .req0(req0), .le0(le0), .dir0(dir0), .dato0(dato0),
      .req1(req1), .le1(le1), .dir1(dir1), .dato1(dato1),
      .gnt0(g0), .gnt1(g1), .ack0(k0), .ack1(k1), .rdato(rd),
      .mem_dir(md), .mem_LE(we), .mem_dato_w(wd),
      .mem_dato_r(32'h0), .ocupado(oc)
    );
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gnt"}, 32'({gnt1, gnt0}), 32'h0);
    chk({tag, ".ack"}, 32'({ack1, ack0}), 32'h0);
    chk({tag, ".le"}, 32'(mem_LE), 32'h0);
    chk({tag, ".ocupado"}, 32'(ocupado), 32'h0);
    chk({tag, ".mem_dir"}, 32'(mem_dir), 32'h0);
    chk({tag, ".dato_w"}, mem_dato_w, 32'h0);
    chk({tag, ".rdato"}, rdato, 32'h0);
  endtask

  // One arbitration round started from REPOSO; ends in the following REPOSO cycle.
  task automatic access(input logic r0, r1, l0, l1, input logic [AW-1:0] a0, a1,
                        input logic [31:0] d0, d1, input bit hold, late1);
    logic          w, l;
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [1:0]    eg;
    w  = (r0 && r1) ? (RR ? !last_ref : 1'b0) : r1;
    last_ref = w;
    l  = w ? l1 : l0;
    a  = w ? a1 : a0;
    d  = w ? d1 : d0;
    eg = w ? 2'b10 : 2'b01;
    req0 = r0; le0 = l0; dir0 = a0; dato0 = d0;
    req1 = r1; le1 = l1; dir1 = a1; dato1 = d1;
    tick();
    if (!hold) begin
      req0 = 1'b0; le0 = 1'($urandom); dir0 = AW'($urandom); dato0 = $urandom;
      if (late1) req1 = 1'b1;
      else begin
        req1 = 1'b0; le1 = 1'($urandom); dir1 = AW'($urandom); dato1 = $urandom;
      end
    end
    for (int k = 1; k <= LAT; k++) begin
      chk("acc.gnt", 32'({gnt1, gnt0}), 32'(eg));
      chk("acc.ack", 32'({ack1, ack0}), 32'h0);
      chk("acc.le", 32'(mem_LE), 32'(l));
      chk("acc.dir", 32'(mem_dir), 32'(a));
      chk("acc.ocupado", 32'(ocupado), 32'h1);
      if (l) chk("acc.dato_w", mem_dato_w, d);
      tick();
    end
    if (l) ref_mem[a] = d;
    else exp_rd = ref_mem[a];
    chk("fin.ack", 32'({ack1, ack0}), 32'(eg));
    chk("fin.gnt", 32'({gnt1, gnt0}), 32'(eg));
    chk("fin.le", 32'(mem_LE), 32'h0);
    chk("fin.rdato", rdato, exp_rd);
    chk("fin.ocupado", 32'(ocupado), 32'h1);
    tick();
    chk("idle.gnt", 32'({gnt1, gnt0}), 32'h0);
    chk("idle.ack", 32'({ack1, ack0}), 32'h0);
    chk("idle.ocupado", 32'(ocupado), 32'h0);
    chk("idle.le", 32'(mem_LE), 32'h0);
    chk("idle.dir", 32'(mem_dir), 32'(a));
  endtask

  initial begin
    int         at [3];
    int         oc [3];
    int         nk [3];
    int         lats [3];
    logic [2:0] kv, ov;
    logic [1:0] rq;
    iCLR = 1'b1;
    req0 = 1'b0; le0 = 1'b0; dir0 = '0; dato0 = '0;
    req1 = 1'b0; le1 = 1'b0; dir1 = '0; dato1 = '0;
    #2 iCLR = 1'b0;
    #1 chk_zero("reset");
    tick();
    tick();
    iCLR = 1'b1;
    last_ref = 1'b1;
    exp_rd = 32'h0;
    // write then read back address 3
    access(1, 0, 1, 0, AW'(3), '0, 32'hCAFE0001, 32'h0, 0, 0);
    access(1, 0, 0, 0, AW'(3), '0, 32'h0, 32'h0, 0, 0);
    chk("readback", rdato, 32'hCAFE0001);
    // both held high for six accesses
    for (int i = 0; i < 6; i++)
      access(1, 1, 1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
             $urandom, $urandom, 1, 0);
    // requester 1 arrives during requester 0 access and must wait
    access(1, 0, 1, 0, AW'(5), AW'(3), 32'h1234_5678, 32'h0, 0, 1);
    access(0, 1, 1, 0, AW'(5), AW'(3), 32'h0, 32'h0, 0, 0);
    // randomized mix of requesters, operations and addresses
    for (int i = 0; i < 24; i++) begin
      rq = 2'($urandom_range(1, 3));
      access(rq[0], rq[1], 1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)),
             AW'($urandom_range(0, 7)), $urandom, $urandom, 0, 0);
    end
    // asynchronous reset pulse in the middle of ACCESO
    req0 = 1'b1; le0 = 1'b1; dir0 = AW'(6); dato0 = 32'hDEAD_BEEF; req1 = 1'b0;
    tick();
    req0 = 1'b0;
    chk("abort.pre", 32'(gnt0), 32'h1);
    #2 iCLR = 1'b0;
    #1 chk_zero("abort");
    #1 iCLR = 1'b1;
    last_ref = 1'b1;
    exp_rd = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort.ack", 32'({ack1, ack0}), 32'h0);
      chk("abort.ocupado", 32'(ocupado), 32'h0);
    end
    access(1, 1, 0, 0, AW'(6), AW'(3), 32'h0, 32'h0, 0, 0);
    // latency sweep across LAT=2, 1 and 15
    iCLR = 1'b0;
    #2 iCLR = 1'b1;
    req0 = 1'b1; le0 = 1'b1; dir0 = AW'(9); dato0 = $urandom; req1 = 1'b0;
    tick();
    req0 = 1'b0;
    lats = '{2, 1, 15};
    at = '{-1, -1, -1};
    oc = '{0, 0, 0};
    nk = '{0, 0, 0};
    for (int t = 1; t <= 20; t++) begin
      kv = {sw[1].k0, sw[0].k0, ack0};
      ov = {sw[1].oc, sw[0].oc, ocupado};
      for (int j = 0; j < 3; j++) begin
        if (kv[j]) begin
          if (at[j] < 0) at[j] = t;
          nk[j]++;
        end
        if (ov[j]) oc[j]++;
      end
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("sweep%0d.ack_at", lats[j]), 32'(at[j]), 32'(lats[j] + 1));
      chk($sformatf("sweep%0d.ack_n", lats[j]), 32'(nk[j]), 32'h1);
      chk($sformatf("sweep%0d.ocupado", lats[j]), 32'(oc[j]), 32'(lats[j] + 1));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
